// File: rtl/int_fp_mul_pipe.sv
// int_fp_mul_pipe: pipelined signed-integer / binary floating-point multiplier
// with a valid/ready stream interface and a single global stall.
//
// Pipeline layers (a beat captured at edge N leaves the output at N+STAGES):
//   layer 0         : operand capture
//   stage 1         : unpack, special-value detection, exponent sum
//   middle stages   : mantissa / integer product, STAGES-2 register layers
//   last stage      : normalise, round, pack into the output registers
//
// Optional build macro INT_FP_MUL_PIPE_TRUNC_EN: when defined, the fp result
// is truncated (round toward zero) instead of rounded to nearest-even.
module int_fp_mul_pipe #(
  parameter int EXP_W  = 5,
  parameter int MAN_W  = 10,
  parameter int INT_W  = 8,
  parameter int STAGES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   c,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   error
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int D  = STAGES - 2;          // number of middle register layers
  localparam int PW = 2 * MAN_W + 2;       // mantissa product width
  localparam int IW = 2 * INT_W;           // integer product width
  localparam int EW = EXP_W + 2;           // signed working exponent width

  localparam logic signed [EW-1:0] BIAS   = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = {EW{1'b0}};
  localparam logic [EXP_W-1:0]     EXP_ONES  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]     EXP_ZERO  = {EXP_W{1'b0}};
  localparam logic [MAN_W-1:0]     MAN_ZERO  = {MAN_W{1'b0}};
  localparam logic [W-2:0]         MAG_ZERO  = {(W-1){1'b0}};
  localparam logic [W-1:0]         C_ZERO    = {W{1'b0}};
  localparam logic [MAN_W:0]       SIG_ZERO  = {(MAN_W+1){1'b0}};
  localparam logic [INT_W-1:0]     INT_ZERO  = {INT_W{1'b0}};

  // Parameter legality is checked at elaboration.
  if (2 * INT_W > W) begin : g_bad_int_w
    $error("int_fp_mul_pipe: 2*INT_W must not exceed W");
  end
  if (STAGES < 2 || STAGES > 6) begin : g_bad_stages
    $error("int_fp_mul_pipe: STAGES must be in 2..6");
  end

  // Payload carried through the middle stages.
  typedef struct packed {
    logic                 mode;
    logic                 sign;
    logic                 zero;
    logic                 inf;
    logic signed [EW-1:0] e;
    logic [PW-1:0]        mprod;
    logic [IW-1:0]        iprod;
  } mid_t;

  localparam mid_t MID_ZERO = {$bits(mid_t){1'b0}};

  // Round-to-nearest-even increment decision from guard, sticky and lsb.
  function automatic logic rne_inc(input logic guard, input logic sticky, input logic lsb);
    return guard & (sticky | lsb);
  endfunction

  // ------------------------------------------------------------------ control
  logic w_advance;
  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance & rst_n;

  // ------------------------------------------------------------------ layer 0
  logic         r_v0;
  logic         r_mode0;
  logic [W-1:0] r_a0;
  logic [W-1:0] r_b0;

  // Capture the operand beat whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v0    <= 1'b0;
      r_mode0 <= 1'b0;
      r_a0    <= C_ZERO;
      r_b0    <= C_ZERO;
    end else if (w_advance) begin
      r_v0    <= in_valid;
      r_mode0 <= mode;
      r_a0    <= a;
      r_b0    <= b;
    end
  end

  // ------------------------------------------------------------------ stage 1
  logic [EXP_W-1:0]     w_ea;
  logic [EXP_W-1:0]     w_eb;
  logic                 w_zero1;
  logic                 w_inf1;
  logic signed [EW-1:0] w_e1;

  assign w_ea    = r_a0[W-2:MAN_W];
  assign w_eb    = r_b0[W-2:MAN_W];
  // Denormal inputs count as zero, and zero beats infinity.
  assign w_zero1 = (w_ea == EXP_ZERO) | (w_eb == EXP_ZERO);
  assign w_inf1  = ~w_zero1 & ((w_ea == EXP_ONES) | (w_eb == EXP_ONES));
  assign w_e1    = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;

  logic                 r_v1;
  logic                 r_mode1;
  logic                 r_sign1;
  logic                 r_zero1;
  logic                 r_inf1;
  logic signed [EW-1:0] r_e1;
  logic [MAN_W:0]       r_ma1;
  logic [MAN_W:0]       r_mb1;
  logic [INT_W-1:0]     r_ia1;
  logic [INT_W-1:0]     r_ib1;

  // Register the unpacked operands, special flags and exponent sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_mode1 <= 1'b0;
      r_sign1 <= 1'b0;
      r_zero1 <= 1'b0;
      r_inf1  <= 1'b0;
      r_e1    <= E_ZERO;
      r_ma1   <= SIG_ZERO;
      r_mb1   <= SIG_ZERO;
      r_ia1   <= INT_ZERO;
      r_ib1   <= INT_ZERO;
    end else if (w_advance) begin
      r_v1    <= r_v0;
      r_mode1 <= r_mode0;
      r_sign1 <= r_a0[W-1] ^ r_b0[W-1];
      r_zero1 <= w_zero1;
      r_inf1  <= w_inf1;
      r_e1    <= w_e1;
      r_ma1   <= {1'b1, r_a0[MAN_W-1:0]};
      r_mb1   <= {1'b1, r_b0[MAN_W-1:0]};
      r_ia1   <= r_a0[INT_W-1:0];
      r_ib1   <= r_b0[INT_W-1:0];
    end
  end

  // ------------------------------------------------------------- products
  logic [PW-1:0]        w_ma_x;
  logic [PW-1:0]        w_mb_x;
  logic signed [IW-1:0] w_ia_x;
  logic signed [IW-1:0] w_ib_x;
  mid_t                 w_p1;

  assign w_ma_x = PW'(r_ma1);
  assign w_mb_x = PW'(r_mb1);
  assign w_ia_x = IW'($signed(r_ia1));
  assign w_ib_x = IW'($signed(r_ib1));

  // Form both products; the middle registers let retiming balance them.
  always_comb begin
    w_p1       = MID_ZERO;
    w_p1.mode  = r_mode1;
    w_p1.sign  = r_sign1;
    w_p1.zero  = r_zero1;
    w_p1.inf   = r_inf1;
    w_p1.e     = r_e1;
    w_p1.mprod = w_ma_x * w_mb_x;
    w_p1.iprod = w_ia_x * w_ib_x;
  end

  // ------------------------------------------------------- middle stages
  mid_t w_fin;
  logic w_fin_v;

  if (D == 0) begin : g_no_mid
    assign w_fin   = w_p1;
    assign w_fin_v = r_v1;
  end else begin : g_mid
    mid_t         r_mid [0:D-1];
    logic [D-1:0] r_mid_v;

    // Shift the product payload down the middle register chain.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < D; i++) begin
          r_mid[i] <= MID_ZERO;
        end
        r_mid_v <= {D{1'b0}};
      end else if (w_advance) begin
        r_mid[0]   <= w_p1;
        r_mid_v[0] <= r_v1;
        for (int i = 1; i < D; i++) begin
          r_mid[i]   <= r_mid[i-1];
          r_mid_v[i] <= r_mid_v[i-1];
        end
      end
    end

    assign w_fin   = r_mid[D-1];
    assign w_fin_v = r_mid_v[D-1];
  end

  // ------------------------------------------------------------ last stage
  logic                 w_top;
  logic [MAN_W-1:0]     w_mant;
  logic                 w_guard;
  logic                 w_sticky;
  logic                 w_inc;
  logic [MAN_W:0]       w_mant_r;
  logic                 w_carry;
  logic [MAN_W-1:0]     w_mant_f;
  logic signed [EW-1:0] w_en;
  logic signed [EW-1:0] w_ef;
  logic [W-1:0]         w_iext;

  // A product in [2,4) has its leading one one place higher.
  assign w_top    = w_fin.mprod[PW-1];
  assign w_mant   = w_top ? w_fin.mprod[PW-2:MAN_W+1] : w_fin.mprod[PW-3:MAN_W];
  assign w_guard  = w_top ? w_fin.mprod[MAN_W] : w_fin.mprod[MAN_W-1];
  assign w_sticky = w_top ? (|w_fin.mprod[MAN_W-1:0]) : (|w_fin.mprod[MAN_W-2:0]);
`ifdef INT_FP_MUL_PIPE_TRUNC_EN
  assign w_inc    = 1'b0;
`else
  assign w_inc    = rne_inc(w_guard, w_sticky, w_mant[0]);
`endif
  assign w_mant_r = {1'b0, w_mant} + {MAN_ZERO, w_inc};
  // A rounding carry leaves the stored mantissa at zero and bumps the exponent.
  assign w_carry  = w_mant_r[MAN_W];
  assign w_mant_f = w_mant_r[MAN_W-1:0];
  assign w_en     = w_fin.e + $signed({{(EW-1){1'b0}}, w_top});
  assign w_ef     = w_en + $signed({{(EW-1){1'b0}}, w_carry});
  assign w_iext   = W'($signed(w_fin.iprod));

  logic [W-1:0] w_c;
  logic         w_ov;
  logic         w_uf;

  // Select the packed result and flags for the beat in the last stage.
  always_comb begin
    w_c  = C_ZERO;
    w_ov = 1'b0;
    w_uf = 1'b0;
    if (!w_fin.mode) begin
      w_c = w_iext;
    end else if (w_fin.zero) begin
      w_c = {w_fin.sign, MAG_ZERO};
    end else if (w_fin.inf) begin
      w_c = {w_fin.sign, EXP_ONES, MAN_ZERO};
    end else if (w_ef >= EMAX) begin
      w_c  = {w_fin.sign, EXP_ONES, MAN_ZERO};
      w_ov = 1'b1;
    end else if (w_ef <= E_ZERO) begin
      w_c  = {w_fin.sign, MAG_ZERO};
      w_uf = 1'b1;
    end else begin
      w_c = {w_fin.sign, w_ef[EXP_W-1:0], w_mant_f};
    end
  end

  // Output registers; they hold while the consumer is stalling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c         <= C_ZERO;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      error     <= 1'b0;
    end else if (w_advance) begin
      out_valid <= w_fin_v;
      c         <= w_fin_v ? w_c : C_ZERO;
      overflow  <= w_fin_v & w_ov;
      underflow <= w_fin_v & w_uf;
      error     <= w_fin_v & (w_ov | w_uf);
    end
  end

endmodule

// File: tb/tb_int_fp_mul_pipe.sv
// Self-checking bench for int_fp_mul_pipe: directed corner cases, randomized
// mixed-mode traffic with random backpressure, a stall burst and a reset
// in mid-stream, all scored against an arithmetic reference model.
module tb_int_fp_mul_pipe;

  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;
  localparam int INT_W  = 8;
  localparam int STAGES = 3;
  localparam int W      = 16;
  localparam int BIAS   = 15;
  localparam int EMAXV  = 31;

`ifdef INT_FP_MUL_PIPE_TRUNC_EN
  localparam logic [15:0] TIE_C = 16'h3E01;
`else
  localparam logic [15:0] TIE_C = 16'h3E02;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic         overflow;
  logic         underflow;
  logic         error;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_out = 0;

  logic [W+1:0] exp_q[$];     // {overflow, underflow, c}
  logic         prev_hold = 1'b0;
  logic [W+3:0] prev_out  = '0;

  always #5 clk = ~clk;

  int_fp_mul_pipe #(
    .EXP_W(EXP_W), .MAN_W(MAN_W), .INT_W(INT_W), .STAGES(STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .overflow(overflow), .underflow(underflow), .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: exact integer product of the significands, then rounding by
  // comparing the discarded remainder against one half ulp.
  function automatic logic [W+1:0] model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    logic   s;
    int     ex, ey, e, sh, ip;
    longint p, q, rem, half;
    if (!m) begin
      ip = int'($signed(x[INT_W-1:0])) * int'($signed(y[INT_W-1:0]));
      return {2'b00, ip[W-1:0]};
    end
    s  = x[W-1] ^ y[W-1];
    ex = int'(x[W-2:MAN_W]);
    ey = int'(y[W-2:MAN_W]);
    if (ex == 0 || ey == 0) return {2'b00, s, 15'h0000};
    if (ex == EMAXV || ey == EMAXV) return {2'b00, s, 5'h1F, 10'h000};
    p  = longint'(1024 + int'(x[MAN_W-1:0])) * longint'(1024 + int'(y[MAN_W-1:0]));
    e  = ex + ey - BIAS;
    sh = MAN_W;
    if (p >= (longint'(1) << (2 * MAN_W + 1))) begin
      sh = sh + 1;
      e  = e + 1;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
`ifndef INT_FP_MUL_PIPE_TRUNC_EN
    if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
    if (q >= (longint'(1) << (MAN_W + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= EMAXV) return {2'b10, s, 5'h1F, 10'h000};
    if (e <= 0)     return {2'b01, s, 15'h0000};
    return {2'b00, s, e[4:0], q[9:0]};
  endfunction

  // Scoreboard: every cycle, check handshake, hold stability and results.
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (!rst_n) begin
      n_acc     = n_acc - exp_q.size();
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("held outputs", {out_valid, error, overflow, underflow, c}, prev_out);
      check("in_ready", in_ready, (!out_valid) || out_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious out_valid", out_valid, 1'b0);
        end else begin
          e = exp_q[0];
          check("result c", c, e[W-1:0]);
          check("overflow", overflow, e[W+1]);
          check("underflow", underflow, e[W]);
          check("error", error, e[W+1] | e[W]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(mode, a, b));
        n_acc++;
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_valid, error, overflow, underflow, c};
    end
  end

  // Single beat on an idle pipe: check latency and literal result.
  task automatic run_one(input string name, input logic m, input logic [15:0] ta, input logic [15:0] tb2,
                         input logic [15:0] ec, input logic eov, input logic euf);
    int k;
    mode = m; a = ta; b = tb2; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({name, " latency"}, k, STAGES);
    check({name, " c"}, c, ec);
    check({name, " ovf"}, overflow, eov);
    check({name, " unf"}, underflow, euf);
    check({name, " err"}, error, eov | euf);
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic m, input logic [15:0] ta, input logic [15:0] tb2);
    int  g;
    logic acc;
    mode = m; a = ta; b = tb2; in_valid = 1'b1;
    g = 0; acc = 1'b0;
    while (!acc && g < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc) check("send timeout", acc, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] bp_a[8] = '{16'h3E00, 16'h00FD, 16'h3C01, 16'h0080, 16'h7BFF, 16'h007F, 16'h8400, 16'h0003};
    logic [15:0] bp_b[8] = '{16'h4000, 16'h0005, 16'h3E00, 16'h0080, 16'h4000, 16'h0081, 16'h0400, 16'h0004};
    int n0, a0;

    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; a = '0; b = '0; out_ready = 1'b1;

    // Pin the reference model with hand-computed values.
    check("model fp basic", model(1'b1, 16'h3E00, 16'h4000), {2'b00, 16'h4200});
    check("model fp tie",   model(1'b1, 16'h3C01, 16'h3E00), {2'b00, TIE_C});
    check("model fp ovf",   model(1'b1, 16'h7BFF, 16'h4000), {2'b10, 16'h7C00});
    check("model int neg",  model(1'b0, 16'h00FD, 16'h0005), {2'b00, 16'hFFF1});

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset c", c, 16'h0000);
    check("reset flags", {overflow, underflow, error}, 3'b000);
    check("reset in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_one("fp basic", 1'b1, 16'h3E00, 16'h4000, 16'h4200, 1'b0, 1'b0);
    run_one("fp tie",   1'b1, 16'h3C01, 16'h3E00, TIE_C,    1'b0, 1'b0);
    run_one("fp ovf",   1'b1, 16'h7BFF, 16'h4000, 16'h7C00, 1'b1, 1'b0);
    run_one("fp unf",   1'b1, 16'h8400, 16'h0400, 16'h8000, 1'b0, 1'b1);
    run_one("fp 0xinf", 1'b1, 16'h0000, 16'h7C00, 16'h0000, 1'b0, 1'b0);
    run_one("fp -inf",  1'b1, 16'hFC00, 16'h3C00, 16'hFC00, 1'b0, 1'b0);
    run_one("int -3x5", 1'b0, 16'h00FD, 16'h0005, 16'hFFF1, 1'b0, 1'b0);
    run_one("int min2", 1'b0, 16'h0080, 16'h0080, 16'h4000, 1'b0, 1'b0);

    // Randomized mixed traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom_range(0, 1));
      a         = 16'($urandom);
      b         = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a[14:10] = 5'($urandom_range(8, 22));
      if ($urandom_range(0, 1) == 1) b[14:10] = 5'($urandom_range(8, 22));
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (STAGES + 3) @(posedge clk);
    #1;

    // Back-to-back stream with a 4-cycle stall in the middle.
    n0 = n_out; a0 = n_acc;
    fork
      begin
        for (int i = 0; i < 8; i++) send(1'(i % 2 == 0), bp_a[i], bp_b[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(posedge clk);
          #1;
          check("stall out_valid", out_valid, 1'b1);
          check("stall in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
      end
    join
    repeat (STAGES + 4) @(posedge clk);
    #1;
    check("stream accepted", n_acc - a0, 8);
    check("stream delivered", n_out - n0, 8);

    // Reset with three beats in flight.
    out_ready = 1'b1;
    send(1'b1, 16'h3E00, 16'h4000);
    send(1'b0, 16'h00FD, 16'h0005);
    send(1'b1, 16'h7BFF, 16'h4000);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1 check("in_ready in reset", in_ready, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("midreset out_valid", out_valid, 1'b0);
    check("midreset c", c, 16'h0000);
    check("midreset flags", {overflow, underflow, error}, 3'b000);
    for (int i = 0; i < STAGES + 4; i++) begin
      @(posedge clk);
      #1;
      check("no stale beat", out_valid, 1'b0);
    end

    check("queue drained", exp_q.size(), 0);
    check("in/out count", n_out, n_acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
